// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: sequences one-frame captures into the binarized frame
// buffer (port A), then hands the frozen buffer to the QR scanner (port B
// owner select plus start/done handshake with timeout).
module frame_capture_ctrl #(
    parameter int unsigned WIDTH          = 480,
    parameter int unsigned HEIGHT         = 480,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        capture_in,
    input  logic        continuous_in,
    input  logic        frame_done_in,
    input  logic        data_valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        we_out,
    output logic [17:0] addr_out,
    output logic        rd_owner_out,
    output logic        scan_start_out,
    input  logic        scan_done_in,
    output logic        busy_out,
    output logic        short_frame_out,
    output logic        timeout_out,
    output logic [7:0]  frames_out
);

    localparam int unsigned AW  = 18;
    localparam int unsigned CW  = 18;
    localparam int unsigned TW  = 22;
    localparam int unsigned FW  = 8;
    localparam int unsigned RW  = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned PIX = WIDTH * HEIGHT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_CHECK,
        S_SCAN
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_tmo;
    logic [RW-1:0] r_retry;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic          r_rd_owner;
    logic          r_scan_start;
    logic          r_busy;
    logic          r_short;
    logic          r_timeout;
    logic [FW-1:0] r_frames;

    logic          w_in_range;
    logic          w_pix_write;
    logic [AW-1:0] w_addr;
    logic          w_count_full;
    logic          w_count_sat;
    logic          w_tmo_last;
    logic          w_retry_left;

    // Pixel qualification and linear address (full 18-bit arithmetic)
    assign w_in_range   = data_valid_in
                          && (32'(hcount_in) < WIDTH)
                          && (32'(vcount_in) < HEIGHT);
    assign w_pix_write  = (r_state == S_CAPTURE) && w_in_range;
    assign w_addr       = AW'(hcount_in) + AW'(WIDTH) * AW'(vcount_in);
    assign w_count_full = (r_count == CW'(PIX));
    assign w_count_sat  = &r_count;
    assign w_tmo_last   = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_retry_left = (r_retry < RW'(MAX_RETRY));

    // Port-A write strobe and address, one cycle behind the pixel
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_we   <= 1'b0;
            r_addr <= '0;
        end else begin
            r_we   <= w_pix_write;
            r_addr <= w_addr;
        end
    end

    // In-range pixel counter: cleared at the aligning frame boundary, saturates
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if ((r_state == S_ARMED) && frame_done_in) begin
            r_count <= '0;
        end else if (w_pix_write && !w_count_sat) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Scan timeout counter: runs only while the scanner owns the buffer
    always_ff @(posedge clk_in) begin
        if (rst_in || (r_state != S_SCAN)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Capture/scan sequencer with registered status and handshake outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_retry      <= '0;
            r_rd_owner   <= 1'b0;
            r_scan_start <= 1'b0;
            r_busy       <= 1'b0;
            r_short      <= 1'b0;
            r_timeout    <= 1'b0;
            r_frames     <= '0;
        end else begin
            r_scan_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (capture_in || continuous_in) begin
                        r_state   <= S_ARMED;
                        r_busy    <= 1'b1;
                        r_short   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_retry   <= '0;
                    end
                end
                S_ARMED: begin
                    // wait for a boundary so the capture starts on a whole frame
                    if (frame_done_in) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (frame_done_in) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_count_full) begin
                        r_state      <= S_SCAN;
                        r_scan_start <= 1'b1;
                        r_rd_owner   <= 1'b1;
                        r_frames     <= r_frames + FW'(1);
                    end else if (w_retry_left) begin
                        r_state <= S_ARMED;
                        r_retry <= r_retry + RW'(1);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_short <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // done has priority over a coincident expiry
                    if (scan_done_in) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_rd_owner <= 1'b0;
                    end else if (w_tmo_last) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_rd_owner <= 1'b0;
                        r_timeout  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_rd_owner <= 1'b0;
                end
            endcase
        end
    end

    assign we_out          = r_we;
    assign addr_out        = r_addr;
    assign rd_owner_out    = r_rd_owner;
    assign scan_start_out  = r_scan_start;
    assign busy_out        = r_busy;
    assign short_frame_out = r_short;
    assign timeout_out     = r_timeout;
    assign frames_out      = r_frames;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: directed checks of frame_capture_ctrl on a small 8x4
// frame with a 100-cycle scan timeout.
module tb_frame_capture_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned H   = 4;
    localparam int unsigned MR  = 3;
    localparam int unsigned TMO = 100;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        capture_in = 1'b0;
    logic        continuous_in = 1'b0;
    logic        frame_done_in = 1'b0;
    logic        data_valid_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        we_out;
    logic [17:0] addr_out;
    logic        rd_owner_out;
    logic        scan_start_out;
    logic        scan_done_in = 1'b0;
    logic        busy_out;
    logic        short_frame_out;
    logic        timeout_out;
    logic [7:0]  frames_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [10:0] h;
        logic [9:0]  v;
        logic        exp_we;
        logic [17:0] exp_addr;
    } vec_t;

    vec_t vecs[12];

    frame_capture_ctrl #(
        .WIDTH(W), .HEIGHT(H), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .capture_in(capture_in),
        .continuous_in(continuous_in),
        .frame_done_in(frame_done_in),
        .data_valid_in(data_valid_in),
        .hcount_in(hcount_in),
        .vcount_in(vcount_in),
        .we_out(we_out),
        .addr_out(addr_out),
        .rd_owner_out(rd_owner_out),
        .scan_start_out(scan_start_out),
        .scan_done_in(scan_done_in),
        .busy_out(busy_out),
        .short_frame_out(short_frame_out),
        .timeout_out(timeout_out),
        .frames_out(frames_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic capture_pulse();
        capture_in = 1'b1;
        step();
        capture_in = 1'b0;
    endtask

    task automatic fd_pulse();
        frame_done_in = 1'b1;
        step();
        frame_done_in = 1'b0;
    endtask

    task automatic done_pulse();
        scan_done_in = 1'b1;
        step();
        scan_done_in = 1'b0;
    endtask

    // Raster of npix valid pixels, hspan per line; optional frame_done on last
    task automatic raster(input int npix, input int hspan, input bit fd_last, input bit check);
        for (int n = 0; n < npix; n++) begin
            int h;
            int v;
            bit inr;
            h = n % hspan;
            v = n / hspan;
            data_valid_in = 1'b1;
            hcount_in     = 11'(h);
            vcount_in     = 10'(v);
            frame_done_in = fd_last && (n == npix - 1);
            step();
            if (check) begin
                inr = (h < int'(W)) && (v < int'(H));
                chk("raster_we", 32'(we_out), 32'(inr));
                if (inr) chk("raster_addr", 32'(addr_out), 32'(h + int'(W) * v));
            end
        end
        data_valid_in = 1'b0;
        frame_done_in = 1'b0;
    endtask

    initial begin
        int c;
        vecs[0]  = '{1'b1, 11'd0,  10'd0, 1'b1, 18'd0};
        vecs[1]  = '{1'b1, 11'd8,  10'd0, 1'b0, 18'd0};
        vecs[2]  = '{1'b1, 11'd3,  10'd0, 1'b1, 18'd3};
        vecs[3]  = '{1'b0, 11'd3,  10'd1, 1'b0, 18'd0};
        vecs[4]  = '{1'b1, 11'd7,  10'd0, 1'b1, 18'd7};
        vecs[5]  = '{1'b1, 11'd2,  10'd4, 1'b0, 18'd0};
        vecs[6]  = '{1'b1, 11'd0,  10'd1, 1'b1, 18'd8};
        vecs[7]  = '{1'b1, 11'd10, 10'd3, 1'b0, 18'd0};
        vecs[8]  = '{1'b1, 11'd5,  10'd2, 1'b1, 18'd21};
        vecs[9]  = '{1'b0, 11'd0,  10'd0, 1'b0, 18'd0};
        vecs[10] = '{1'b1, 11'd7,  10'd3, 1'b1, 18'd31};
        vecs[11] = '{1'b1, 11'd8,  10'd3, 1'b0, 18'd0};

        // Reset state
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        chk("rst_we", 32'(we_out), 0);
        chk("rst_addr", 32'(addr_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_owner", 32'(rd_owner_out), 0);
        chk("rst_start", 32'(scan_start_out), 0);
        chk("rst_frames", 32'(frames_out), 0);
        chk("rst_flags", 32'({short_frame_out, timeout_out}), 0);

        // Table-driven capture: mixed in/out-of-range pixels, then fill the frame
        capture_pulse();
        chk("arm_busy", 32'(busy_out), 1);
        fd_pulse();
        chk("cap_we_idle", 32'(we_out), 0);
        for (int i = 0; i < 12; i++) begin
            data_valid_in = vecs[i].valid;
            hcount_in     = vecs[i].h;
            vcount_in     = vecs[i].v;
            step();
            chk("vec_we", 32'(we_out), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) chk("vec_addr", 32'(addr_out), 32'(vecs[i].exp_addr));
        end
        raster(26, W, 1'b1, 1'b1);
        chk("check_start", 32'(scan_start_out), 0);
        chk("check_busy", 32'(busy_out), 1);
        chk("check_owner", 32'(rd_owner_out), 0);
        step();
        chk("scan_start", 32'(scan_start_out), 1);
        chk("scan_owner", 32'(rd_owner_out), 1);
        chk("scan_frames", 32'(frames_out), 1);
        step();
        chk("scan_start_once", 32'(scan_start_out), 0);
        chk("scan_owner2", 32'(rd_owner_out), 1);
        done_pulse();
        chk("done_owner", 32'(rd_owner_out), 0);
        chk("done_busy", 32'(busy_out), 0);
        chk("done_tmo", 32'(timeout_out), 0);

        // Oversized raster: only h<W written; then scan times out
        capture_pulse();
        fd_pulse();
        raster(int'((W + 4) * H), int'(W + 4), 1'b1, 1'b1);
        step();
        chk("wide_start", 32'(scan_start_out), 1);
        chk("wide_frames", 32'(frames_out), 2);
        c = 1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (rd_owner_out) c++;
            else break;
        end
        chk("tmo_len", 32'(c), TMO);
        chk("tmo_flag", 32'(timeout_out), 1);
        chk("tmo_busy", 32'(busy_out), 0);

        // Done coincident with expiry: done wins
        capture_pulse();
        chk("tmo_clear", 32'(timeout_out), 0);
        fd_pulse();
        raster(int'(W * H), W, 1'b1, 1'b1);
        step();
        chk("co_frames", 32'(frames_out), 3);
        repeat (TMO - 1) step();
        chk("co_owner", 32'(rd_owner_out), 1);
        done_pulse();
        chk("co_tmo", 32'(timeout_out), 0);
        chk("co_owner_drop", 32'(rd_owner_out), 0);
        step();
        chk("co_tmo2", 32'(timeout_out), 0);

        // Short frames: first attempt plus MR retries, then give up
        capture_pulse();
        for (int a = 0; a <= int'(MR); a++) begin
            fd_pulse();
            raster(int'(W * H) - 1, W, 1'b0, 1'b1);
            fd_pulse();
            step();
            if (a < int'(MR)) begin
                chk("retry_busy", 32'(busy_out), 1);
                chk("retry_short", 32'(short_frame_out), 0);
            end else begin
                chk("giveup_busy", 32'(busy_out), 0);
                chk("giveup_short", 32'(short_frame_out), 1);
            end
        end
        chk("short_frames", 32'(frames_out), 3);
        capture_pulse();
        chk("short_clear", 32'(short_frame_out), 0);

        // Reset mid-capture abandons the frame
        fd_pulse();
        raster(20, W, 1'b0, 1'b0);
        data_valid_in = 1'b1;
        hcount_in     = 11'd4;
        vcount_in     = 10'd2;
        rst_in        = 1'b1;
        step();
        rst_in        = 1'b0;
        data_valid_in = 1'b0;
        chk("mid_rst_we", 32'(we_out), 0);
        chk("mid_rst_addr", 32'(addr_out), 0);
        chk("mid_rst_busy", 32'(busy_out), 0);
        chk("mid_rst_frames", 32'(frames_out), 0);
        fd_pulse();
        step();
        chk("post_rst_busy", 32'(busy_out), 0);
        raster(8, W, 1'b0, 1'b0);
        chk("post_rst_we", 32'(we_out), 0);

        // Continuous mode: re-arm after each scan, ignore capture/fd in SCAN
        continuous_in = 1'b1;
        step();
        chk("cont_busy", 32'(busy_out), 1);
        fd_pulse();
        raster(int'(W * H), W, 1'b1, 1'b1);
        step();
        chk("cont_start1", 32'(scan_start_out), 1);
        chk("cont_frames1", 32'(frames_out), 1);
        capture_in    = 1'b1;
        frame_done_in = 1'b1;
        step();
        capture_in    = 1'b0;
        frame_done_in = 1'b0;
        chk("cont_scan_owner", 32'(rd_owner_out), 1);
        chk("cont_scan_nostart", 32'(scan_start_out), 0);
        repeat (8) step();
        done_pulse();
        chk("cont_idle_busy", 32'(busy_out), 0);
        chk("cont_idle_owner", 32'(rd_owner_out), 0);
        step();
        chk("cont_rearm", 32'(busy_out), 1);
        data_valid_in = 1'b1;
        hcount_in     = 11'd1;
        vcount_in     = 10'd0;
        step();
        data_valid_in = 1'b0;
        chk("armed_no_we", 32'(we_out), 0);
        fd_pulse();
        raster(int'(W * H), W, 1'b1, 1'b1);
        step();
        chk("cont_start2", 32'(scan_start_out), 1);
        chk("cont_frames2", 32'(frames_out), 2);
        continuous_in = 1'b0;
        done_pulse();
        step();
        chk("cont_off_busy", 32'(busy_out), 0);
        chk("cont_off_frames", 32'(frames_out), 2);

        // Reset during SCAN releases the buffer
        capture_pulse();
        fd_pulse();
        raster(int'(W * H), W, 1'b1, 1'b1);
        step();
        chk("rs_start", 32'(scan_start_out), 1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("rs_owner", 32'(rd_owner_out), 0);
        chk("rs_frames", 32'(frames_out), 0);
        step();
        chk("rs_nostart", 32'(scan_start_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
